inert_seq: RTL and testbench

- Controller that sequences the SPI_mnrch monarch to configure and read the iNEMO inertial sensor.
- After reset it waits a power-up interval, then issues a fixed write sequence to configure the sensor.
- On each data-ready INT it performs a six-register read burst and assembles the bytes into 16-bit pitch, roll and yaw.
- Sits between SPI_mnrch and the downstream integrator; it is the sole owner of the SPI cmd/snd interface.

---
 rtl/inert_pkg.sv | 28 ++
 rtl/inert_if.sv | 10 +
 rtl/inert_sync.sv | 22 ++
 rtl/inert_seq.sv | 191 +++++++++++++++++++
 tb/tb_inert_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/inert_pkg.sv
// Shared types and command tables for the iNEMO sequencer.
package inert_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        CFG_SND,
        CFG_WAIT,
        IDLE,
        RD_SND,
        RD_WAIT,
        VLD
    } state_t;

    localparam int CFG_N     = 4;
    localparam int RD_N      = 6;
    localparam int CFG_IDX_W = 2;
    localparam int IDX_W     = 3;

    // Packed tables: element 0 is the rightmost entry.
    localparam logic [CFG_N-1:0][15:0] CFG_CMD = {
        16'h1460, 16'h1162, 16'h1062, 16'h0D02
    };

    localparam logic [RD_N-1:0][15:0] RD_CMD = {
        16'hA700, 16'hA600, 16'hA500, 16'hA400, 16'hA300, 16'hA200
    };

endpackage

// File: rtl/inert_if.sv
// Command/response handshake between the sequencer and SPI_mnrch.
interface inert_if;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;

    modport master (output snd, output cmd, input done, input resp);
    modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/inert_sync.sv
// Two-flop synchronizer followed by an edge flop; rise pulses one cycle per low-to-high.
module inert_sync (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic rise
);

    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], a};
    end

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/inert_seq.sv
// iNEMO sequencer: power-up wait, config writes, then six-byte read burst per INT.
// Optional SPI_TMO_EN adds a per-transaction timeout that sets the sticky err flag.
module inert_seq
    import inert_pkg::*;
#(
    parameter int PWRUP_CYC = 65535,
    parameter int TMO_CYC   = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    inert_if.master     spi,
    output logic [15:0] ptch,
    output logic [15:0] roll,
    output logic [15:0] yaw,
    output logic        vld,
    output logic        cfg_done,
    output logic        err
);

    localparam int PW_W = $clog2(PWRUP_CYC + 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [PW_W-1:0]        pwr_q, pwr_d;
    logic                   pend_q, pend_d;
    logic                   done_q, done_d;
    logic                   snd_q, snd_d;
    logic [15:0]            cmd_q, cmd_d;
    logic [RD_N-1:0][7:0]   byte_q, byte_d;
    logic [15:0]            ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
    logic                   vld_q, vld_d;
    logic                   cfg_done_q, cfg_done_d;
    logic                   int_rise, done_rise;

    inert_sync u_int_sync (.clk(clk), .rst(rst), .a(INT), .rise(int_rise));

    assign done_d    = spi.done;
    assign done_rise = spi.done & ~done_q;

`ifdef SPI_TMO_EN
    localparam int TM_W = $clog2(TMO_CYC + 1);
    logic [TM_W-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pwr_d      = pwr_q;
        pend_d     = pend_q | (int_rise && state_q != IDLE);
        snd_d      = 1'b0;
        cmd_d      = cmd_q;
        byte_d     = byte_q;
        ptch_d     = ptch_q;
        roll_d     = roll_q;
        yaw_d      = yaw_q;
        vld_d      = 1'b0;
        cfg_done_d = cfg_done_q;

        case (state_q)
            PWRUP: begin
                if (pwr_q == '0) state_d = CFG_SND;
                else             pwr_d   = pwr_q - 1'b1;
            end
            CFG_SND: begin
                cmd_d   = CFG_CMD[idx_q[CFG_IDX_W-1:0]];
                snd_d   = 1'b1;
                state_d = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (done_rise) begin
                    if (idx_q == IDX_W'(CFG_N - 1)) begin
                        cfg_done_d = 1'b1;
                        idx_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = CFG_SND;
                    end
                end
            end
            IDLE: begin
                if (int_rise || pend_q) begin
                    pend_d  = 1'b0;
                    idx_d   = '0;
                    state_d = RD_SND;
                end
            end
            RD_SND: begin
                cmd_d   = RD_CMD[idx_q];
                snd_d   = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (done_rise) begin
                    byte_d[idx_q] = spi.resp[7:0];
                    if (idx_q == IDX_W'(RD_N - 1)) begin
                        // yawH is still on resp this cycle; use it directly so vld lands 1 clk after the edge
                        ptch_d  = {byte_q[1], byte_q[0]};
                        roll_d  = {byte_q[3], byte_q[2]};
                        yaw_d   = {spi.resp[7:0], byte_q[4]};
                        vld_d   = 1'b1;
                        state_d = VLD;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RD_SND;
                    end
                end
            end
            VLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = PWRUP;
            end
        endcase

`ifdef SPI_TMO_EN
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q == CFG_SND || state_q == RD_SND) begin
            tmo_d = TM_W'(TMO_CYC - 1);
        end else if ((state_q == CFG_WAIT || state_q == RD_WAIT) && !done_rise) begin
            if (tmo_q == '0) begin
                err_d   = 1'b1;
                idx_d   = '0;
                state_d = (state_q == CFG_WAIT) ? CFG_SND : IDLE;
            end else begin
                tmo_d = tmo_q - 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PWRUP;
            idx_q      <= '0;
            pwr_q      <= PW_W'(PWRUP_CYC - 1);
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            snd_q      <= 1'b0;
            cmd_q      <= '0;
            byte_q     <= '0;
            ptch_q     <= '0;
            roll_q     <= '0;
            yaw_q      <= '0;
            vld_q      <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pwr_q      <= pwr_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            snd_q      <= snd_d;
            cmd_q      <= cmd_d;
            byte_q     <= byte_d;
            ptch_q     <= ptch_d;
            roll_q     <= roll_d;
            yaw_q      <= yaw_d;
            vld_q      <= vld_d;
            cfg_done_q <= cfg_done_d;
        end
    end

`ifdef SPI_TMO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign spi.snd  = snd_q;
    assign spi.cmd  = cmd_q;
    assign ptch     = ptch_q;
    assign roll     = roll_q;
    assign yaw      = yaw_q;
    assign vld      = vld_q;
    assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_inert_seq.sv
// Directed/randomized bench for inert_seq with a behavioural SPI_iNEMO slave model.
module tb_inert_seq;

    localparam int PWRUP = 20;
    localparam int TMO   = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        int_in = 1'b0;
    logic [15:0] ptch, roll, yaw;
    logic        vld, cfg_done, err;

    inert_if spi ();

    inert_seq #(.PWRUP_CYC(PWRUP), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .INT(int_in), .spi(spi),
        .ptch(ptch), .roll(roll), .yaw(yaw),
        .vld(vld), .cfg_done(cfg_done), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] sens [3];
    int          drop_delay = 0;
    bit          withhold_en = 1'b0;
    bit          outstanding = 1'b0;
    int          completions = 0;
    logic [15:0] snd_log [$];
    logic [47:0] vld_log [$];

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] reg_byte(input logic [7:0] a);
        case (a)
            8'hA2:   return sens[0][7:0];
            8'hA3:   return sens[0][15:8];
            8'hA4:   return sens[1][7:0];
            8'hA5:   return sens[1][15:8];
            8'hA6:   return sens[2][7:0];
            8'hA7:   return sens[2][15:8];
            default: return 8'($urandom);
        endcase
    endfunction

    // SPI_iNEMO + monarch model: done drops after snd (optionally late), rises after a random latency.
    initial begin : slave
        int cnt, drop;
        bit busy;
        logic [15:0] cur;
        busy = 1'b0; cnt = 0; drop = 0; cur = '0;
        spi.done = 1'b0;
        spi.resp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0; drop = 0;
                spi.done = 1'b0;
            end else if (spi.snd) begin
                cur  = spi.cmd;
                busy = !(withhold_en && cur == 16'hA500);
                drop = drop_delay;
                cnt  = int'($urandom_range(6, 2)) + drop_delay;
                if (drop == 0) spi.done = 1'b0;
                else           spi.resp = 16'hEEEE;
            end else begin
                if (drop > 0) begin
                    drop--;
                    if (drop == 0) spi.done = 1'b0;
                end
                if (busy) begin
                    if (cnt <= 1) begin
                        busy = 1'b0;
                        spi.resp = {8'($urandom), reg_byte(cur[15:8])};
                        spi.done = 1'b1;
                        outstanding = 1'b0;
                        completions++;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 1'b0;
        end else begin
            if (spi.snd) begin
                chk("snd_overlap", 48'(outstanding), 48'd0);
                outstanding = !(withhold_en && spi.cmd == 16'hA500);
                snd_log.push_back(spi.cmd);
            end
            if (vld) vld_log.push_back({ptch, roll, yaw});
        end
    end

    task automatic pulse_int();
        int_in = 1'b1;
        repeat (3) @(negedge clk);
        int_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_vld(input int n, input string tag);
        int k = 0;
        while (vld_log.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 48'(vld_log.size()), 48'(n));
    endtask

    task automatic check_burst(input int base, input string tag);
        logic [15:0] e;
        for (int i = 0; i < 6; i++) begin
            e = {8'(8'hA2 + i), 8'h00};
            chk($sformatf("%s_cmd%0d", tag, i), 48'(snd_log[base + i]), 48'(e));
        end
    endtask

    task automatic power_up(input string tag);
        int k = 0;
        logic [15:0] cfg [4];
        cfg[0] = 16'h0D02; cfg[1] = 16'h1062; cfg[2] = 16'h1162; cfg[3] = 16'h1460;
        snd_log.delete();
        completions = 0;
        while (!spi.snd && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_pwrup_gap"}, 48'(k > PWRUP && k <= PWRUP + 3), 48'd1);
        k = 0;
        while (!cfg_done && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_cfg_done_after_4"}, 48'(completions), 48'd4);
        chk({tag, "_cfg_snd_count"}, 48'(snd_log.size()), 48'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_cfg_cmd%0d", tag, i), 48'(snd_log[i]), 48'(cfg[i]));
    endtask

    function automatic logic [47:0] rand_sens();
        for (int i = 0; i < 3; i++) sens[i] = 16'($urandom);
        return {sens[0], sens[1], sens[2]};
    endfunction

    initial begin : stim
        logic [47:0] exp;
        int k;

        repeat (3) @(negedge clk);
        chk("rst_snd", 48'(spi.snd), 48'd0);
        chk("rst_cmd", 48'(spi.cmd), 48'd0);
        chk("rst_data", {ptch, roll, yaw}, 48'd0);
        chk("rst_vld", 48'(vld), 48'd0);
        chk("rst_cfg_done", 48'(cfg_done), 48'd0);
        chk("rst_err", 48'(err), 48'd0);
        rst = 1'b0;

        power_up("boot");

        // Directed burst with the reference sensor values.
        sens[0] = 16'h1234; sens[1] = 16'hFEDC; sens[2] = 16'h0081;
        snd_log.delete(); vld_log.delete();
        pulse_int();
        wait_vld(1, "burst1_vld");
        check_burst(0, "burst1");
        chk("burst1_data", vld_log[0], {16'h1234, 16'hFEDC, 16'h0081});
        repeat (5) @(negedge clk);
        chk("burst1_vld_once", 48'(vld_log.size()), 48'd1);

        // INT edge mid-burst becomes a single pending request.
        exp = rand_sens();
        snd_log.delete(); vld_log.delete();
        k = completions;
        pulse_int();
        while (completions < k + 2 && completions < k + 100) @(negedge clk);
        pulse_int();
        wait_vld(2, "pend_vld");
        check_burst(0, "pend_a");
        check_burst(6, "pend_b");
        chk("pend_data_a", vld_log[0], exp);
        chk("pend_data_b", vld_log[1], exp);
        repeat (60) @(negedge clk);
        chk("pend_merged_snd", 48'(snd_log.size()), 48'd12);

        // done left high after snd must not count as completion.
        drop_delay = 3;
        exp = rand_sens();
        snd_log.delete(); vld_log.delete();
        pulse_int();
        wait_vld(1, "stale_vld");
        check_burst(0, "stale");
        chk("stale_data", vld_log[0], exp);
        drop_delay = 0;

        // Reset during the third read.
        snd_log.delete(); vld_log.delete();
        pulse_int();
        k = 0;
        while (snd_log.size() < 3 && k < 500) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_snd", 48'(spi.snd), 48'd0);
        chk("midrst_cmd", 48'(spi.cmd), 48'd0);
        chk("midrst_data", {ptch, roll, yaw}, 48'd0);
        chk("midrst_cfg_done", 48'(cfg_done), 48'd0);
        @(negedge clk);
        rst = 1'b0;
        vld_log.delete();
        power_up("reboot");
        chk("reboot_data_zero", {ptch, roll, yaw}, 48'd0);
        chk("reboot_no_vld", 48'(vld_log.size()), 48'd0);
        exp = rand_sens();
        snd_log.delete();
        pulse_int();
        wait_vld(1, "reboot_vld");
        check_burst(0, "reboot");
        chk("reboot_data", vld_log[0], exp);

`ifdef SPI_TMO_EN
        withhold_en = 1'b1;
        snd_log.delete(); vld_log.delete();
        int_in = 1'b1;
        k = 0;
        while (!(spi.snd && spi.cmd == 16'hA500) && k < 500) begin
            @(negedge clk);
            k++;
        end
        int_in = 1'b0;
        k = 0;
        while (!err && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_cycles", 48'(k), 48'(TMO));
        repeat (10) @(negedge clk);
        chk("tmo_no_vld", 48'(vld_log.size()), 48'd0);
        chk("tmo_snd_count", 48'(snd_log.size()), 48'd4);
        withhold_en = 1'b0;
        exp = rand_sens();
        snd_log.delete();
        pulse_int();
        wait_vld(1, "tmo_next_vld");
        check_burst(0, "tmo_next");
        chk("tmo_next_data", vld_log[0], exp);
        chk("tmo_err_sticky", 48'(err), 48'd1);
`else
        chk("err_tied", 48'(err), 48'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
